rob_state_update: RTL and testbench

Reorder buffer for the backend state-update path, receiving side of the execute-to-ROB interface. Rename allocates entries in program order. The three execute pipes mark entries complete, with a branch-mispredict flag and a redirect target. Completed entries retire in order, one per cycle, returning the old physical register to the freelist. A mispredicted branch redirects the front end and flushes the buffer when that branch reaches the head.

---
 rtl/rob_state_update.sv | 138 +++++++++++++
 tb/tb_rob_state_update.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_state_update.sv
// Reorder buffer: in-order allocate, out-of-order completion from three execute
// pipes, in-order single retire with mispredict flush at the head.
module rob_state_update #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned AREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  input  logic              alloc_is_br,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [2:0]        su_valid,
  input  logic [TAG_W-1:0]  su_tag [3],
  input  logic [2:0]        su_br_mispred,
  input  logic [31:0]       su_target [3],
  output logic              retire_valid,
  output logic [AREG_W-1:0] retire_areg,
  output logic [PREG_W-1:0] retire_preg,
  output logic [PREG_W-1:0] retire_old_preg,
  output logic              flush_valid,
  output logic [31:0]       flush_target,
  output logic [TAG_W:0]    count
);

  localparam int unsigned PW = TAG_W + 1;

  logic [PW-1:0]     head_q, tail_q;
  logic [DEPTH-1:0]  valid_q, done_q, mispred_q, is_br_q;
  logic [AREG_W-1:0] areg_q     [DEPTH];
  logic [PREG_W-1:0] preg_q     [DEPTH];
  logic [PREG_W-1:0] old_preg_q [DEPTH];
  logic [31:0]       target_q   [DEPTH];

  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              full, head_flush, alloc_fire, retire_fire;
  logic [DEPTH-1:0]  cmp_hit, cmp_mis;
  logic [31:0]       cmp_tgt [DEPTH];

  assign head_idx    = head_q[TAG_W-1:0];
  assign tail_idx    = tail_q[TAG_W-1:0];
  assign full        = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign retire_fire = valid_q[head_idx] && done_q[head_idx];
  assign head_flush  = retire_fire && mispred_q[head_idx];
  assign alloc_ready = !full && !flush_valid && !head_flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_idx;

  // Walk ports high to low so the lowest-numbered mispredicting port's target wins.
  always_comb begin
    cmp_hit = '0;
    cmp_mis = '0;
    for (int i = 0; i < DEPTH; i++) cmp_tgt[i] = '0;
    for (int p = 2; p >= 0; p--) begin
      if (su_valid[p]) begin
        cmp_hit[su_tag[p]] = 1'b1;
        if (su_br_mispred[p]) begin
          cmp_mis[su_tag[p]] = 1'b1;
          cmp_tgt[su_tag[p]] = su_target[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      valid_q         <= '0;
      done_q          <= '0;
      mispred_q       <= '0;
      is_br_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        areg_q[i]     <= '0;
        preg_q[i]     <= '0;
        old_preg_q[i] <= '0;
        target_q[i]   <= '0;
      end
      retire_valid    <= 1'b0;
      retire_areg     <= '0;
      retire_preg     <= '0;
      retire_old_preg <= '0;
      flush_valid     <= 1'b0;
      flush_target    <= '0;
      count           <= '0;
    end else begin
      retire_valid <= 1'b0;
      flush_valid  <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cmp_hit[i]) begin
          done_q[i] <= 1'b1;
          if (cmp_mis[i] && is_br_q[i]) begin
            mispred_q[i] <= 1'b1;
            target_q[i]  <= cmp_tgt[i];
          end
        end
      end

      if (alloc_fire) begin
        valid_q[tail_idx]    <= 1'b1;
        done_q[tail_idx]     <= 1'b0;
        mispred_q[tail_idx]  <= 1'b0;
        is_br_q[tail_idx]    <= alloc_is_br;
        areg_q[tail_idx]     <= alloc_areg;
        preg_q[tail_idx]     <= alloc_preg;
        old_preg_q[tail_idx] <= alloc_old_preg;
        target_q[tail_idx]   <= '0;
        tail_q               <= tail_q + PW'(1);
      end

      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PW'(1);
        retire_valid      <= 1'b1;
        retire_areg       <= areg_q[head_idx];
        retire_preg       <= preg_q[head_idx];
        retire_old_preg   <= old_preg_q[head_idx];
        // Flush overrides every valid bit; alloc is already blocked by head_flush.
        if (mispred_q[head_idx]) begin
          flush_valid  <= 1'b1;
          flush_target <= target_q[head_idx];
          valid_q      <= '0;
          tail_q       <= head_q + PW'(1);
        end
      end

      if (head_flush) count <= '0;
      else            count <= count + PW'(alloc_fire) - PW'(retire_fire);
    end
  end

endmodule

// File: tb/tb_rob_state_update.sv
// Directed self-checking bench for rob_state_update.
module tb_rob_state_update;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [4:0]  alloc_areg;
  logic [5:0]  alloc_preg;
  logic [5:0]  alloc_old_preg;
  logic        alloc_is_br;
  logic [3:0]  alloc_tag;
  logic [2:0]  su_valid;
  logic [3:0]  su_tag [3];
  logic [2:0]  su_br_mispred;
  logic [31:0] su_target [3];
  logic        retire_valid;
  logic [4:0]  retire_areg;
  logic [5:0]  retire_preg;
  logic [5:0]  retire_old_preg;
  logic        flush_valid;
  logic [31:0] flush_target;
  logic [4:0]  count;

  int tests;
  int fails;

  rob_state_update #(
    .DEPTH (16),
    .TAG_W (4),
    .PREG_W(6),
    .AREG_W(5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_areg     (alloc_areg),
    .alloc_preg     (alloc_preg),
    .alloc_old_preg (alloc_old_preg),
    .alloc_is_br    (alloc_is_br),
    .alloc_tag      (alloc_tag),
    .su_valid       (su_valid),
    .su_tag         (su_tag),
    .su_br_mispred  (su_br_mispred),
    .su_target      (su_target),
    .retire_valid   (retire_valid),
    .retire_areg    (retire_areg),
    .retire_preg    (retire_preg),
    .retire_old_preg(retire_old_preg),
    .flush_valid    (flush_valid),
    .flush_target   (flush_target),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    alloc_valid    = 1'b0;
    alloc_areg     = '0;
    alloc_preg     = '0;
    alloc_old_preg = '0;
    alloc_is_br    = 1'b0;
    su_valid       = '0;
    su_br_mispred  = '0;
    for (int p = 0; p < 3; p++) begin
      su_tag[p]    = '0;
      su_target[p] = '0;
    end
  endtask

  task automatic set_alloc(input int areg, input logic is_br);
    alloc_valid    = 1'b1;
    alloc_areg     = 5'(areg);
    alloc_preg     = 6'(areg + 10);
    alloc_old_preg = 6'(areg + 20);
    alloc_is_br    = is_br;
  endtask

  task automatic set_su(input int p, input int tag, input logic mis, input logic [31:0] tgt);
    su_valid[p]      = 1'b1;
    su_tag[p]        = 4'(tag);
    su_br_mispred[p] = mis;
    su_target[p]     = tgt;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_tag", 32'(alloc_tag), 0);
    check("rst_retire_valid", 32'(retire_valid), 0);
    check("rst_retire_areg", 32'(retire_areg), 0);
    check("rst_flush_valid", 32'(flush_valid), 0);
    check("rst_flush_target", flush_target, 0);

    // In-order retire despite out-of-order completion
    for (int i = 1; i <= 3; i++) begin
      set_alloc(i, 1'b0);
      step();
    end
    clear_inputs();
    check("t1_count3", 32'(count), 3);
    check("t1_tag3", 32'(alloc_tag), 3);
    set_su(0, 2, 1'b0, 0);
    step();
    clear_inputs();
    check("t1_no_ret_a", 32'(retire_valid), 0);
    set_su(0, 0, 1'b0, 0);
    step();
    clear_inputs();
    check("t1_no_ret_b", 32'(retire_valid), 0);
    set_su(0, 1, 1'b0, 0);
    step();
    clear_inputs();
    check("t1_ret1_v", 32'(retire_valid), 1);
    check("t1_ret1_areg", 32'(retire_areg), 1);
    check("t1_ret1_preg", 32'(retire_preg), 11);
    check("t1_ret1_old", 32'(retire_old_preg), 21);
    check("t1_ret1_count", 32'(count), 2);
    step();
    check("t1_ret2_v", 32'(retire_valid), 1);
    check("t1_ret2_areg", 32'(retire_areg), 2);
    check("t1_ret2_count", 32'(count), 1);
    step();
    check("t1_ret3_v", 32'(retire_valid), 1);
    check("t1_ret3_areg", 32'(retire_areg), 3);
    check("t1_ret3_count", 32'(count), 0);
    step();
    check("t1_idle_v", 32'(retire_valid), 0);
    check("t1_hold_areg", 32'(retire_areg), 3);

    // Fill, no-bypass when full, wrap-around tag
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check("t2_fill_ready", 32'(alloc_ready), 1);
      check("t2_fill_tag", 32'(alloc_tag), 32'(i));
      set_alloc(i, 1'b0);
      step();
    end
    check("t2_full_ready", 32'(alloc_ready), 0);
    check("t2_full_count", 32'(count), 16);
    step();
    check("t2_full_hold", 32'(count), 16);
    clear_inputs();
    set_su(1, 0, 1'b0, 0);
    step();
    clear_inputs();
    check("t2_done_ready", 32'(alloc_ready), 0);
    set_alloc(30, 1'b0);
    step();
    check("t2_ret_v", 32'(retire_valid), 1);
    check("t2_ret_areg", 32'(retire_areg), 0);
    check("t2_nobypass", 32'(count), 15);
    check("t2_ready_back", 32'(alloc_ready), 1);
    check("t2_wrap_tag", 32'(alloc_tag), 0);
    step();
    clear_inputs();
    check("t2_refill", 32'(count), 16);

    // Branch mispredict flush; two ports on the same branch, lowest port target wins
    do_reset();
    set_alloc(7, 1'b1);
    step();
    set_alloc(8, 1'b0);
    step();
    set_alloc(9, 1'b0);
    step();
    clear_inputs();
    set_su(2, 0, 1'b1, 32'h0000_5678);
    set_su(1, 0, 1'b1, 32'h0000_1234);
    step();
    clear_inputs();
    check("t3_headflush_ready", 32'(alloc_ready), 0);
    check("t3_pre_ret", 32'(retire_valid), 0);
    set_su(0, 1, 1'b0, 0);
    step();
    clear_inputs();
    check("t3_ret_v", 32'(retire_valid), 1);
    check("t3_ret_areg", 32'(retire_areg), 7);
    check("t3_flush_v", 32'(flush_valid), 1);
    check("t3_flush_tgt", flush_target, 32'h0000_1234);
    check("t3_flush_count", 32'(count), 0);
    check("t3_flush_ready", 32'(alloc_ready), 0);
    step();
    check("t3_post_flush_v", 32'(flush_valid), 0);
    check("t3_post_ret_v", 32'(retire_valid), 0);
    check("t3_post_ready", 32'(alloc_ready), 1);
    check("t3_post_tag", 32'(alloc_tag), 1);
    check("t3_post_count", 32'(count), 0);
    set_alloc(9, 1'b0);
    step();
    clear_inputs();
    step();
    step();
    check("t3_discarded_cmp", 32'(retire_valid), 0);
    check("t3_count1", 32'(count), 1);

    // Three completions in one cycle; non-branch ignores the mispredict flag
    do_reset();
    for (int i = 4; i <= 6; i++) begin
      set_alloc(i, 1'b0);
      step();
    end
    clear_inputs();
    set_su(0, 0, 1'b0, 0);
    set_su(1, 1, 1'b1, 32'hdead_beef);
    set_su(2, 2, 1'b0, 0);
    step();
    clear_inputs();
    check("t4_pre_ret", 32'(retire_valid), 0);
    step();
    check("t4_ret_a", 32'(retire_areg), 4);
    check("t4_ret_a_v", 32'(retire_valid), 1);
    step();
    check("t4_ret_b", 32'(retire_areg), 5);
    check("t4_ret_b_v", 32'(retire_valid), 1);
    check("t4_no_flush", 32'(flush_valid), 0);
    step();
    check("t4_ret_c", 32'(retire_areg), 6);
    check("t4_ret_c_v", 32'(retire_valid), 1);
    step();
    check("t4_idle", 32'(retire_valid), 0);
    check("t4_count0", 32'(count), 0);

    // Completion to an unallocated tag is ignored
    set_su(0, 5, 1'b0, 0);
    step();
    clear_inputs();
    check("t5_count", 32'(count), 0);
    check("t5_ret", 32'(retire_valid), 0);
    check("t5_tag", 32'(alloc_tag), 3);
    for (int i = 1; i <= 3; i++) begin
      set_alloc(i, 1'b0);
      step();
    end
    clear_inputs();
    set_su(0, 3, 1'b0, 0);
    set_su(1, 4, 1'b0, 0);
    step();
    clear_inputs();
    step();
    check("t5_ret3", 32'(retire_areg), 1);
    step();
    check("t5_ret4", 32'(retire_areg), 2);
    step();
    check("t5_tag5_not_done", 32'(retire_valid), 0);
    check("t5_count1", 32'(count), 1);

    // Asynchronous reset with entries in flight
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(i + 1, 1'b0);
      step();
    end
    clear_inputs();
    set_su(0, 0, 1'b0, 0);
    set_su(1, 1, 1'b0, 0);
    set_su(2, 2, 1'b0, 0);
    step();
    clear_inputs();
    step();
    check("t6_pre_ret_v", 32'(retire_valid), 1);
    check("t6_pre_count", 32'(count), 7);
    #2 rst = 1'b0;
    #1;
    check("t6_async_ret_v", 32'(retire_valid), 0);
    check("t6_async_areg", 32'(retire_areg), 0);
    check("t6_async_count", 32'(count), 0);
    check("t6_async_tag", 32'(alloc_tag), 0);
    step();
    rst = 1'b1;
    step();
    check("t6_after_ret_v", 32'(retire_valid), 0);
    step();
    check("t6_after_ret_v2", 32'(retire_valid), 0);
    check("t6_after_count", 32'(count), 0);
    check("t6_after_ready", 32'(alloc_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
